muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 149 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : 32-iteration shift-add multiply / restoring divide for HI/LO
// Revision : 1.0
// ============================================================================
module muldiv_sequencer (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Flush,
  output logic        Stall,
  output logic        Busy,
  output logic        Hi_Write,
  output logic        Lo_Write,
  output logic [31:0] Hi_out,
  output logic [31:0] Lo_out,
  output logic        Done,
  output logic        DivZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] c_LAST = 6'd31;

  state_t      r_state;
  logic [5:0]  r_count;
  logic        r_isDiv;
  logic        r_negRes;
  logic        r_negRem;
  logic        r_divZero;
  logic [31:0] r_rawA;
  logic [31:0] r_opB;
  logic [63:0] r_acc;

  logic        w_signed;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic        w_accept;
  logic [32:0] w_sum;
  logic        w_ge;
  logic [31:0] w_trial;
  logic [63:0] w_accNext;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_hiFix;
  logic [31:0] w_loFix;

  assign w_signed = ~Op[0];
  assign w_absA   = (w_signed && SrcA[31]) ? (~SrcA + 32'd1) : SrcA;
  assign w_absB   = (w_signed && SrcB[31]) ? (~SrcB + 32'd1) : SrcB;
  assign w_accept = (r_state == IDLE) && Start && !Flush;

  assign Stall = w_accept || (r_state == RUN);
  assign Busy  = (r_state == RUN);

  // Multiply keeps {partial product, remaining multiplier}; divide keeps {rem, quot}.
  assign w_sum   = r_acc[0] ? ({1'b0, r_acc[63:32]} + {1'b0, r_opB}) : {1'b0, r_acc[63:32]};
  assign w_ge    = r_acc[63:31] >= {1'b0, r_opB};
  assign w_trial = r_acc[62:31] - r_opB;

  always_comb begin
    w_accNext = {w_sum, r_acc[31:1]};
    if (r_isDiv) begin
      w_accNext = w_ge ? {w_trial, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
    end
  end

  assign w_prod = r_negRes ? (~w_accNext + 64'd1) : w_accNext;
  assign w_quot = r_negRes ? (~w_accNext[31:0] + 32'd1) : w_accNext[31:0];
  assign w_rem  = r_negRem ? (~w_accNext[63:32] + 32'd1) : w_accNext[63:32];

  always_comb begin
    w_hiFix = w_prod[63:32];
    w_loFix = w_prod[31:0];
    if (r_isDiv) begin
      w_hiFix = r_divZero ? r_rawA : w_rem;
      w_loFix = r_divZero ? 32'hFFFF_FFFF : w_quot;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_count   <= 6'd0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_rawA    <= 32'd0;
      r_opB     <= 32'd0;
      r_acc     <= 64'd0;
      Hi_Write  <= 1'b0;
      Lo_Write  <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
      Hi_out    <= 32'd0;
      Lo_out    <= 32'd0;
    end else begin
      Hi_Write <= 1'b0;
      Lo_Write <= 1'b0;
      Done     <= 1'b0;
      DivZero  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= RUN;
            r_count   <= 6'd0;
            r_isDiv   <= Op[1];
            r_rawA    <= SrcA;
            r_negRes  <= w_signed && (SrcA[31] ^ SrcB[31]);
            r_negRem  <= w_signed && SrcA[31];
            r_divZero <= Op[1] && (SrcB == 32'd0);
            r_opB     <= Op[1] ? w_absB : w_absA;
            r_acc     <= {32'd0, Op[1] ? w_absA : w_absB};
          end
        end
        RUN: begin
          if (Flush) begin
            r_state <= IDLE;
          end else begin
            r_acc   <= w_accNext;
            r_count <= r_count + 6'd1;
            if (r_count == c_LAST) begin
              r_state  <= DONE;
              Hi_Write <= 1'b1;
              Lo_Write <= 1'b1;
              Done     <= 1'b1;
              DivZero  <= r_divZero;
              Hi_out   <= w_hiFix;
              Lo_out   <= w_loFix;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : directed checks of multiply, divide, flush and reset
// Revision : 1.0
// ============================================================================
module tb_muldiv_sequencer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        Flush = 1'b0;
  logic        Stall, Busy, Hi_Write, Lo_Write, Done, DivZero;
  logic [31:0] Hi_out, Lo_out;

  int errCount = 0;
  int checkCount = 0;

  muldiv_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .Stall(Stall), .Busy(Busy), .Hi_Write(Hi_Write),
    .Lo_Write(Lo_Write), .Hi_out(Hi_out), .Lo_out(Lo_out), .Done(Done),
    .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    #1 check("stall_cycle0", Stall, 1);
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // Issues one op, checks stall over cycles 1..32, then the cycle-33 write and cycle-34 hold.
  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi,
                       input logic [31:0] expLo, input logic expDz);
    int bad;
    bad = 0;
    issue(op, a, b);
    for (int c = 1; c <= 32; c++) begin
      if (!Stall || !Busy || Done || Hi_Write) bad++;
      @(posedge Clk); #1;
    end
    check({tag, "_run_cycles"}, bad, 0);
    check({tag, "_strobes"}, {Hi_Write, Lo_Write, Done, Stall, Busy}, 5'b11100);
    check({tag, "_result"}, {Hi_out, Lo_out}, {expHi, expLo});
    check({tag, "_divzero"}, DivZero, expDz);
    @(posedge Clk); #1;
    check({tag, "_after"}, {Hi_Write, Lo_Write, Done, DivZero, Busy, Hi_out, Lo_out},
          {5'b00000, expHi, expLo});
  endtask

  initial begin
    #12;
    check("reset_outputs", {Stall, Busy, Hi_Write, Lo_Write, Done, DivZero, Hi_out, Lo_out}, 70'd0);
    @(negedge Clk); Rst = 1'b0;

    runOp("mult_7x-3",  2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    runOp("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    runOp("mult_neg2",  2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'd6, 1'b0);
    runOp("div_-7by2",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runOp("div_7by-2",  2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    runOp("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    runOp("divu_1000by7", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);
    runOp("divu_by0",   2'b11, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1);
    runOp("div_-5by0",  2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

    // Start together with Flush in IDLE is refused.
    @(negedge Clk);
    Start = 1'b1; Flush = 1'b1; Op = 2'b01; SrcA = 32'd9; SrcB = 32'd9;
    #1 check("flush_start_stall", Stall, 0);
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0;
    check("flush_start_busy", Busy, 0);

    // Flush mid-run: back to IDLE with no write and outputs holding.
    issue(2'b11, 32'd1000, 32'd7);
    repeat (9) begin @(posedge Clk); #1; end
    check("flush_busy_before", Busy, 1);
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flush_idle", {Busy, Stall, Hi_Write, Lo_Write, Done, Hi_out, Lo_out},
          {5'b00000, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
    repeat (3) begin @(posedge Clk); #1; end
    check("flush_no_write", {Hi_Write, Done, Hi_out, Lo_out}, {2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
    runOp("multu_3x5", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

    // Asynchronous reset in the middle of a run.
    issue(2'b00, 32'd123, 32'd456);
    repeat (19) begin @(posedge Clk); #1; end
    #2 Rst = 1'b1;
    #1 check("async_reset", {Stall, Busy, Hi_Write, Lo_Write, Done, DivZero, Hi_out, Lo_out}, 70'd0);
    @(negedge Clk); Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1 check("reset_no_write", {Busy, Done, Hi_out, Lo_out}, 66'd0);
    runOp("mult_2x3", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
`default_nettype wire
